// File: rtl/link_hang_monitor.sv
// rtl/link_hang_monitor.sv - transparent NoC link monitor with packet framing and hang alarm
// Forwards flits/credits untouched; flags packets that stall GAP_MAX cycles mid-packet.
module link_hang_monitor #(
   parameter logic [15:0] ADDRESS = 16'b0,
   parameter string       PORT    = "",
   parameter int          GAP_MAX = 32,
   parameter int          CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rx_i,
   output logic             cr_rx_o,
   input  logic             eop_rx_i,
   input  logic [31:0]      data_rx_i,
   output logic             tx_o,
   input  logic             cr_tx_i,
   output logic             eop_tx_o,
   output logic [31:0]      data_tx_o,
   output logic             alarm_o,
   input  logic             alarm_clr_i,
   output logic [CNT_W-1:0] hang_count_o,
   output logic [CNT_W-1:0] pkt_count_o,
   output logic [31:0]      last_service_o
);
   timeunit 1ns;
   timeprecision 1ps;

   localparam logic [15:0]      GAP_LIM = 16'(GAP_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {HEADER, SIZE, SERVICE, PAYLOAD} state_t;

   state_t      state_q, state_d;
   logic [15:0] gap_cnt;
   logic        xfer;
   logic        hang_event;

   assign tx_o      = rx_i;
   assign cr_rx_o   = cr_tx_i;
   assign eop_tx_o  = eop_rx_i;
   assign data_tx_o = data_rx_i;

   assign xfer = rx_i && cr_tx_i;
   // Fires only on the GAP_MAX-1 -> GAP_MAX step; the counter then holds, so one event per gap.
   assign hang_event = (state_q != HEADER) && !xfer && (gap_cnt == GAP_LIM - 16'd1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= HEADER;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (xfer) begin
         if (eop_rx_i) begin
            state_d = HEADER;
         end else begin
            case (state_q)
               HEADER:  state_d = SIZE;
               SIZE:    state_d = SERVICE;
               SERVICE: state_d = PAYLOAD;
               default: state_d = PAYLOAD;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gap_cnt <= 16'd0;
      end else if (state_q == HEADER || xfer) begin
         gap_cnt <= 16'd0;
      end else if (gap_cnt < GAP_LIM) begin
         gap_cnt <= gap_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alarm_o        <= 1'b0;
         hang_count_o   <= '0;
         pkt_count_o    <= '0;
         last_service_o <= 32'd0;
      end else begin
         // A new hang outranks a simultaneous clear request.
         if (hang_event) begin
            alarm_o <= 1'b1;
            if (hang_count_o != '1) hang_count_o <= hang_count_o + CNT_ONE;
         end else if (alarm_clr_i) begin
            alarm_o <= 1'b0;
         end
         if (xfer && eop_rx_i) pkt_count_o <= pkt_count_o + CNT_ONE;
         if (xfer && state_q == SERVICE) last_service_o <= data_rx_i;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i && hang_event)
         $display("[%0.6f ms] [HM %02h x %02h-%s] Link hang detected",
                  $realtime / 1.0e6, ADDRESS[15:8], ADDRESS[7:0], PORT);
   end
`endif

endmodule

// File: tb/tb_link_hang_monitor.sv
// tb/tb_link_hang_monitor.sv - randomized self-checking bench for link_hang_monitor
// Reference model tracks flit position in packet and raw idle-run length as plain integers.
module tb_link_hang_monitor;
   timeunit 1ns;
   timeprecision 1ps;

   localparam int GAP_MAX = 32;
   localparam int CNT_W   = 16;

   logic             clk = 1'b0;
   logic             rst_i = 1'b0;
   logic             rx_i = 1'b0, eop_rx_i = 1'b0, cr_tx_i = 1'b0, alarm_clr_i = 1'b0;
   logic [31:0]      data_rx_i = 32'd0;
   logic             cr_rx_o, tx_o, eop_tx_o, alarm_o;
   logic [31:0]      data_tx_o, last_service_o;
   logic [CNT_W-1:0] hang_count_o, pkt_count_o;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int          m_pos;      // flits already accepted in current packet (0 = expecting header)
   int          m_idle;     // consecutive idle cycles spent inside a packet
   logic        m_alarm;
   int          m_hang;
   int          m_pkt;
   logic [31:0] m_svc;

   always #5 clk = ~clk;

   link_hang_monitor #(
      .ADDRESS(16'h0102), .PORT("E"), .GAP_MAX(GAP_MAX), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .rx_i(rx_i), .cr_rx_o(cr_rx_o), .eop_rx_i(eop_rx_i), .data_rx_i(data_rx_i),
      .tx_o(tx_o), .cr_tx_i(cr_tx_i), .eop_tx_o(eop_tx_o), .data_tx_o(data_tx_o),
      .alarm_o(alarm_o), .alarm_clr_i(alarm_clr_i),
      .hang_count_o(hang_count_o), .pkt_count_o(pkt_count_o),
      .last_service_o(last_service_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_idle = 0; m_alarm = 1'b0; m_hang = 0; m_pkt = 0; m_svc = 32'd0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".alarm"}, 32'(alarm_o), 32'(m_alarm));
      chk({tag, ".hang"},  32'(hang_count_o), 32'(m_hang));
      chk({tag, ".pkt"},   32'(pkt_count_o), 32'(m_pkt % (1 << CNT_W)));
      chk({tag, ".svc"},   last_service_o, m_svc);
   endtask

   task automatic check_pass(input string tag);
      chk({tag, ".tx"},   32'(tx_o), 32'(rx_i));
      chk({tag, ".cr"},   32'(cr_rx_o), 32'(cr_tx_i));
      chk({tag, ".eop"},  32'(eop_tx_o), 32'(eop_rx_i));
      chk({tag, ".data"}, data_tx_o, data_rx_i);
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cyc(input logic rx, input logic cr, input logic eop,
                      input logic [31:0] d, input logic clr);
      logic hang_now;
      rx_i = rx; cr_tx_i = cr; eop_rx_i = eop; data_rx_i = d; alarm_clr_i = clr;
      #1;
      check_pass("pass");
      @(posedge clk);
      hang_now = 1'b0;
      if (rx && cr) begin
         if (m_pos == 2) m_svc = d;
         if (eop) begin
            m_pos = 0;
            m_pkt++;
         end else begin
            m_pos++;
         end
         m_idle = 0;
      end else if (m_pos != 0) begin
         m_idle++;
         if (m_idle == GAP_MAX) hang_now = 1'b1;
      end else begin
         m_idle = 0;
      end
      if (hang_now) begin
         m_alarm = 1'b1;
         if (m_hang != (1 << CNT_W) - 1) m_hang++;
      end else if (clr) begin
         m_alarm = 1'b0;
      end
      @(negedge clk);
      check_regs("cyc");
   endtask

   task automatic flit(input logic [31:0] d, input logic eop);
      cyc(1'b1, 1'b1, eop, d, 1'b0);
   endtask

   task automatic idle(input int n, input logic rx, input logic cr);
      for (int i = 0; i < n; i++) cyc(rx, cr, 1'b0, $urandom, 1'b0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      rx_i = 1'b1; cr_tx_i = 1'b0; eop_rx_i = 1'b1; data_rx_i = $urandom; alarm_clr_i = 1'b0;
      #1;
      model_reset();
      check_regs("rst");
      check_pass("rst_pass");
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      rx_i = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // basic 5-flit packet
      flit(32'hAAAA_0001, 1'b0); flit(32'd2, 1'b0); flit(32'h1, 1'b0);
      flit(32'h5555_0000, 1'b0); flit(32'h5555_0001, 1'b1);
      chk("basic.pkt", 32'(pkt_count_o), 32'd1);
      chk("basic.svc", last_service_o, 32'h1);
      chk("basic.alarm", 32'(alarm_o), 32'd0);

      // gap just below threshold
      do_reset();
      flit(32'h10, 1'b0); flit(32'd1, 1'b0); flit(32'h22, 1'b0);
      idle(GAP_MAX - 1, 1'b0, 1'b1);
      flit(32'h33, 1'b1);
      chk("below.alarm", 32'(alarm_o), 32'd0);
      chk("below.hang", 32'(hang_count_o), 32'd0);

      // gap past threshold: one event, alarm exactly at cycle GAP_MAX
      do_reset();
      flit(32'h10, 1'b0); flit(32'd1, 1'b0); flit(32'h44, 1'b0);
      idle(GAP_MAX - 1, 1'b0, 1'b0);
      chk("at.pre_alarm", 32'(alarm_o), 32'd0);
      idle(1, 1'b0, 1'b0);
      chk("at.alarm", 32'(alarm_o), 32'd1);
      idle(40 - GAP_MAX, 1'b0, 1'b0);
      flit(32'h55, 1'b1);
      chk("at.hang", 32'(hang_count_o), 32'd1);
      chk("at.pkt", 32'(pkt_count_o), 32'd1);

      // backpressure counts as idle, then clear/set race
      flit(32'h10, 1'b0); flit(32'd3, 1'b0); flit(32'h66, 1'b0); flit(32'h77, 1'b0);
      idle(GAP_MAX, 1'b1, 1'b0);
      chk("bp.hang", 32'(hang_count_o), 32'd2);
      flit(32'h78, 1'b0);
      idle(GAP_MAX - 1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("race.alarm", 32'(alarm_o), 32'd1);
      chk("race.hang", 32'(hang_count_o), 32'd3);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("clr.alarm", 32'(alarm_o), 32'd0);

      // reset mid-packet, long idle in HEADER, then 3-flit packet
      do_reset();
      idle(100, 1'b0, 1'b1);
      idle(20, 1'b1, 1'b0);
      flit(32'h1, 1'b0); flit(32'h2, 1'b0); flit(32'hCAFE_F00D, 1'b1);
      chk("post.pkt", 32'(pkt_count_o), 32'd1);
      chk("post.svc", last_service_o, 32'hCAFE_F00D);
      chk("post.alarm", 32'(alarm_o), 32'd0);

      // randomized traffic with occasional long stalls and clears
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 29) == 0) begin
            idle($urandom_range(GAP_MAX - 3, GAP_MAX + 6), 1'($urandom_range(0, 1)), 1'b0);
         end else begin
            cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 8),
                1'($urandom_range(0, 4) == 0), $urandom, 1'($urandom_range(0, 19) == 0));
         end
         if (k == 750) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
